// File: rtl/uart_sched_pkg.sv
// Shared types and helpers for the UART transmit scheduler and its arbiter.
package uart_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE
    } SCHED_STATE_TYPE;

    localparam int SCHED_START_TIMEOUT = 16;
    localparam int SCHED_MAX_REQ       = 8;

    function automatic logic [SCHED_MAX_REQ-1:0] onehot(input int unsigned idx);
        onehot = SCHED_MAX_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_picker.sv
// Combinational round-robin picker: first set request scanning upward from ptr+1, wrapping.
module rr_picker #(
    parameter int N_REQ = 2,
    localparam int PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic             valid,
    output logic [PTR_W-1:0] winner
);

    // Walk the offsets from farthest to nearest so the nearest set request is the last write.
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            if (req[(int'(ptr) + k) % N_REQ]) begin
                valid  = 1'b1;
                winner = PTR_W'((int'(ptr) + k) % N_REQ);
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART byte transmitter between N_REQ requesters: round-robin pick,
// byte held for the frame, one-cycle start pulse, start-timeout recovery.
//
// state     | meaning
// IDLE      | arbitrate when transmitter is free and a request is pending
// LAUNCH    | tx_flag and grant asserted for this single cycle
// WAIT_BUSY | waiting for transmitter busy to rise, start timeout running
// WAIT_DONE | frame in progress, waiting for busy to fall
module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter int N_REQ         = 2,
    parameter int DATA_W        = 8,
    parameter int START_TIMEOUT = SCHED_START_TIMEOUT
) (
    input  logic                    CLK,
    input  logic                    RESET_N,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        grant,
    output logic [DATA_W-1:0]       tx_data,
    output logic                    tx_flag,
    input  logic                    tx_busy,
    output logic                    active,
    output logic [7:0]              err_count
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(START_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_TIMEOUT - 1);

    SCHED_STATE_TYPE   state, state_next;
    logic [PTR_W-1:0]  ptr, ptr_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic [DATA_W-1:0] data_next;
    logic [N_REQ-1:0]  grant_next;
    logic              flag_next;
    logic [7:0]        err_next;
    logic              pick_valid;
    logic [PTR_W-1:0]  pick_winner;

    rr_picker #(.N_REQ(N_REQ)) u_picker (
        .req    (req),
        .ptr    (ptr),
        .valid  (pick_valid),
        .winner (pick_winner)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= IDLE;
            ptr       <= PTR_W'(N_REQ - 1);
            cnt       <= '0;
            tx_data   <= '0;
            grant     <= '0;
            tx_flag   <= 1'b0;
            err_count <= '0;
        end else begin
            state     <= state_next;
            ptr       <= ptr_next;
            cnt       <= cnt_next;
            tx_data   <= data_next;
            grant     <= grant_next;
            tx_flag   <= flag_next;
            err_count <= err_next;
        end
    end

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        cnt_next   = cnt;
        data_next  = tx_data;
        grant_next = '0;
        flag_next  = 1'b0;
        err_next   = err_count;
        case (state)
            IDLE: begin
                if (!tx_busy && pick_valid) begin
                    data_next  = req_data[int'(pick_winner)*DATA_W +: DATA_W];
                    grant_next = N_REQ'(onehot(int'(pick_winner)));
                    flag_next  = 1'b1;
                    ptr_next   = pick_winner;
                    state_next = LAUNCH;
                end
            end
            LAUNCH: begin
                cnt_next   = '0;
                state_next = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                // Busy takes priority over a timeout landing in the same cycle.
                if (tx_busy) begin
                    state_next = WAIT_DONE;
                end else if (cnt == CNT_LAST) begin
                    state_next = IDLE;
                    if (err_count != 8'hFF) err_next = err_count + 8'd1;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign active = (state != IDLE);

endmodule
